// File: rtl/ext_share_arbiter.sv
// Round-robin arbiter sharing one width-extension unit among NUM_INPUTS elastic requesters.
// Define EXT_SHARE_ARBITER_SIGNED_EN to sign-extend instead of zero-extend.
module ext_share_arbiter #(
   parameter int NUM_INPUTS = 2,
   parameter int INPUT_WIDTH = 32,
   parameter int OUTPUT_WIDTH = 64,
   localparam int INDEX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_INPUTS*INPUT_WIDTH-1:0] ins,
   input  logic [NUM_INPUTS-1:0]             ins_valid,
   output logic [NUM_INPUTS-1:0]             ins_ready,
   output logic [OUTPUT_WIDTH-1:0]           outs,
   output logic [INDEX_WIDTH-1:0]            outs_index,
   output logic                              outs_valid,
   input  logic                              outs_ready
);

   logic [INDEX_WIDTH-1:0]  ptr;
   logic [INDEX_WIDTH-1:0]  grant_idx;
   logic [INDEX_WIDTH-1:0]  ptr_next;
   logic                    found;
   logic                    can_accept;
   logic                    accept;
   logic [INPUT_WIDTH-1:0]  operand;
   logic [OUTPUT_WIDTH-1:0] extended;

   // Search ins_valid starting at ptr, wrapping, and take the first hit.
   always_comb begin
      int j;
      j = 0;
      found = 1'b0;
      grant_idx = '0;
      operand = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_INPUTS) begin
            j = j - NUM_INPUTS;
         end
         if (!found && ins_valid[j]) begin
            found = 1'b1;
            grant_idx = INDEX_WIDTH'(j);
            operand = ins[j*INPUT_WIDTH +: INPUT_WIDTH];
         end
      end
   end

   // Reset gates acceptance so no requester sees a handshake it would lose.
   assign can_accept = !rst && (!outs_valid || outs_ready);
   assign accept = found && can_accept;

   always_comb begin
      ins_ready = '0;
      if (accept) begin
         ins_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      if (int'(grant_idx) == NUM_INPUTS - 1) begin
         ptr_next = '0;
      end else begin
         ptr_next = grant_idx + INDEX_WIDTH'(1);
      end
   end

   always_comb begin
`ifdef EXT_SHARE_ARBITER_SIGNED_EN
      extended = {OUTPUT_WIDTH{operand[INPUT_WIDTH-1]}};
`else
      extended = '0;
`endif
      extended[INPUT_WIDTH-1:0] = operand;
   end

   // One-slot output register; ptr advances only when a requester is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         outs_valid <= 1'b0;
         outs <= '0;
         outs_index <= '0;
         ptr <= '0;
      end else if (accept) begin
         outs_valid <= 1'b1;
         outs <= extended;
         outs_index <= grant_idx;
         ptr <= ptr_next;
      end else if (outs_ready) begin
         outs_valid <= 1'b0;
      end
   end

endmodule

// File: doc/ext_share_arbiter.md
Name: ext_share_arbiter

Overview:
Shares one unsigned width-extension datapath (INPUT_WIDTH -> OUTPUT_WIDTH, zero-fill) among NUM_INPUTS elastic requesters. Arbitrates round-robin, extends the granted operand and holds the result in a one-slot output register. The output is tagged with the winner's index so a downstream demux can route it back. Sits in dataflow circuits where several extui-style operations are mapped onto one shared unit by resource sharing.

Parameters:
NUM_INPUTS, 2, number of requesters (>=1)
INPUT_WIDTH, 32, operand width
OUTPUT_WIDTH, 64, result width (>= INPUT_WIDTH)
INDEX_WIDTH, derived max(1, clog2(NUM_INPUTS)), width of outs_index

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ins  in  NUM_INPUTS*INPUT_WIDTH  operands; requester i occupies bits [i*INPUT_WIDTH +: INPUT_WIDTH]
ins_valid  in  NUM_INPUTS  per-requester valid
ins_ready  out  NUM_INPUTS  per-requester ready (one-hot or zero)
outs  out  OUTPUT_WIDTH  extended result (registered)
outs_index  out  INDEX_WIDTH  requester that produced outs
outs_valid  out  1  result valid
outs_ready  in  1  downstream ready

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: outs_valid=0, outs=0, outs_index=0, round-robin pointer ptr=0. Any slot contents are discarded, including a result pending mid-transfer.
- Slot: one register holding {outs, outs_index}, plus full flag = outs_valid.
- can_accept = !outs_valid | outs_ready. Pass-through: full throughput of 1 result per cycle when downstream is always ready.
- Grant: combinational search of ins_valid starting at index ptr, wrapping modulo NUM_INPUTS. The first valid index found is g.
- ins_ready[g] = can_accept. All other ins_ready bits are 0. ins_ready is all-zero when no input is valid.
- ins_ready depends combinationally on outs_ready and ins_valid. It must not depend on ins_ready of other units.
- Accept (ins_valid[g] & ins_ready[g]), on the next edge:
  - outs <= zero-extend(ins[g]): operand in low INPUT_WIDTH bits, upper bits 0.
  - outs_index <= g, outs_valid <= 1, ptr <= (g+1) mod NUM_INPUTS.
- No accept and outs_ready=1: outs_valid <= 0. outs and outs_index keep their values (don't-care).
- Stall (outs_valid & !outs_ready): outs and outs_index hold stable; all ins_ready = 0.
- Latency: 1 cycle from accept to outs_valid.
- Fairness: a continuously valid requester is granted within NUM_INPUTS accepts.
- NUM_INPUTS=1: ptr is constant 0 and the block degenerates to a one-slot elastic buffer.
- OUTPUT_WIDTH == INPUT_WIDTH: outs = operand unchanged.
- ptr updates only on accept. A requester that drops valid before being granted loses nothing and is skipped.

Optional Feature:
- Macro: EXT_SHARE_ARBITER_SIGNED_EN.
- When defined: the extension replicates operand bit INPUT_WIDTH-1 into the upper bits (sign extension). Everything else is unchanged.
- When undefined: zero extension as described above.
- Both variants have identical ports and timing.

Test Plan:
- Reset check: assert rst for 2 cycles while all ins_valid=1 -> outs_valid=0, outs=0, outs_index=0, ins_ready=0 during reset. After release the first grant goes to index 0.
- Single requester: NUM_INPUTS=2, W 8->16, ins_valid=01, ins[0]=0xA5, outs_ready=1 -> next cycle outs=0x00A5, outs_index=0, outs_valid=1. With EXT_SHARE_ARBITER_SIGNED_EN, outs=0xFFA5.
- Round-robin: NUM_INPUTS=3, all valid for 6 cycles, outs_ready=1 -> outs_index sequence 0,1,2,0,1,2, one result per cycle, exactly one ins_ready bit high each cycle.
- Backpressure: slot full, outs_ready=0 for 3 cycles -> outs and outs_index stable, ins_ready=000. Raise outs_ready -> same cycle ins_ready for the next requester goes high (pass-through), with no bubble.
- Skip and wrap: ptr=2, ins_valid=011 -> grant index 0, then ptr=1. Next grant index 1 if still valid.
- Mid-operation reset: outs_valid=1 with outs_ready=0, assert rst one cycle -> outs_valid=0 and ptr=0 next cycle. The pending result is dropped.
